base12_seq_alu: RTL and testbench

Parametrised, digit-serial duodecimal ALU operating on packed base-12 operands (one 4-bit nibble per digit, value 0..11), width set by `DIGITS`. Successor to the fixed 16-bit base-12 ALU. Adds:
- valid/ready handshakes on both sides, with output backpressure;
- digit-exact add/sub with carry/borrow out;
- single-digit multiply;
- digit shifts;
- compare;
- invalid-digit/illegal-op error reporting.

It sits between the command decoder and the result writeback stage of the duodecimal datapath.

---
 rtl/base12_seq_alu_if.sv | 25 ++
 rtl/base12_seq_alu.sv | 187 ++++++++++++++++++
 tb/tb_base12_seq_alu.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/base12_seq_alu_if.sv
// Handshake bundle for the digit-serial base-12 ALU: command side in, result side out.
interface base12_seq_alu_if #(
  parameter int DIGITS = 6
);
  logic                  in_valid;
  logic                  in_ready;
  logic [2:0]            op;
  logic [4*DIGITS-1:0]   a;
  logic [4*DIGITS-1:0]   b;
  logic                  out_valid;
  logic                  out_ready;
  logic [4*DIGITS-1:0]   result;
  logic                  carry_out;
  logic                  error;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, carry_out, error
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, carry_out, error
  );
endinterface

// File: rtl/base12_seq_alu.sv
// Digit-serial duodecimal ALU: one base-12 digit per RUN cycle, LSD first, with
// valid/ready handshakes and invalid-digit / illegal-op rejection.
module base12_seq_alu #(
  parameter int DIGITS = 6
) (
  input logic            clk,
  input logic            reset,
  base12_seq_alu_if.slave bus
);
  localparam int W = 4 * DIGITS;
  localparam logic [3:0] LAST = 4'(DIGITS - 1);

  typedef enum logic [1:0] {IDLE, RUN, OUT} state_t;
  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_MULD = 3'b010,
    OP_SHL  = 3'b011,
    OP_SHR  = 3'b100,
    OP_CMP  = 3'b101
  } op_t;

  state_t         state, state_n;
  logic [2:0]     op_r, op_n;
  logic [W-1:0]   a_r, a_n, b_r, b_n, res_r, res_n;
  logic [3:0]     cnt, cnt_n;
  logic [3:0]     acc, acc_n, acc_step;
  logic           carry_r, carry_n, error_r, error_n;
  logic [3:0]     ai, bi, k, dig;
  logic [4:0]     sum5, src;
  logic [5:0]     diff6;
  logic [7:0]     prod8;

  // Out-of-range indices read as 0, which is exactly the shift fill digit.
  function automatic logic [3:0] digit_at(input logic [W-1:0] v, input logic [4:0] idx);
    logic [3:0] d;
    d = '0;
    for (int unsigned j = 0; j < DIGITS; j++)
      if (idx == j[4:0]) d = v[4*j +: 4];
    return d;
  endfunction

  function automatic logic bad_digits(input logic [W-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int unsigned j = 0; j < DIGITS; j++)
      if (v[4*j +: 4] > 4'd11) bad = 1'b1;
    return bad;
  endfunction

  // Per-digit datapath; acc carries c / brw / multiply carry / compare code.
  always_comb begin
    ai       = digit_at(a_r, {1'b0, cnt});
    bi       = digit_at(b_r, {1'b0, cnt});
    k        = b_r[3:0];
    dig      = '0;
    acc_step = acc;
    sum5     = '0;
    diff6    = '0;
    prod8    = '0;
    src      = '0;
    case (op_r)
      OP_ADD: begin
        sum5 = {1'b0, ai} + {1'b0, bi} + {1'b0, acc};
        if (sum5 >= 5'd12) begin
          dig      = 4'(sum5 - 5'd12);
          acc_step = 4'd1;
        end else begin
          dig      = sum5[3:0];
          acc_step = 4'd0;
        end
      end
      OP_SUB: begin
        diff6 = {2'b0, ai} - {2'b0, bi} - {2'b0, acc};
        if (diff6[5]) begin
          dig      = 4'(diff6 + 6'd12);
          acc_step = 4'd1;
        end else begin
          dig      = diff6[3:0];
          acc_step = 4'd0;
        end
      end
      OP_MULD: begin
        prod8    = {4'b0, ai} * {4'b0, k} + {4'b0, acc};
        dig      = 4'(prod8 % 8'd12);
        acc_step = 4'(prod8 / 8'd12);
      end
      OP_SHL: begin
        src = {1'b0, cnt} - {1'b0, k};
        if (cnt >= k) dig = digit_at(a_r, src);
      end
      OP_SHR: begin
        src = {1'b0, cnt} + {1'b0, k};
        dig = digit_at(a_r, src);
      end
      OP_CMP: begin
        if (ai > bi)      acc_step = 4'd1;
        else if (ai < bi) acc_step = 4'd2;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_n = state;
    op_n    = op_r;
    a_n     = a_r;
    b_n     = b_r;
    res_n   = res_r;
    cnt_n   = cnt;
    acc_n   = acc;
    carry_n = carry_r;
    error_n = error_r;
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          op_n    = bus.op;
          a_n     = bus.a;
          b_n     = bus.b;
          cnt_n   = '0;
          acc_n   = '0;
          res_n   = '0;
          carry_n = 1'b0;
          if (bus.op > 3'd5 || bad_digits(bus.a) || bad_digits(bus.b)) begin
            error_n = 1'b1;
            state_n = OUT;
          end else begin
            error_n = 1'b0;
            state_n = RUN;
          end
        end
      end
      RUN: begin
        for (int unsigned j = 0; j < DIGITS; j++)
          if (cnt == j[3:0]) res_n[4*j +: 4] = dig;
        acc_n = acc_step;
        cnt_n = cnt + 4'd1;
        if (cnt == LAST) begin
          state_n = OUT;
          case (op_r)
            OP_ADD, OP_SUB: carry_n = acc_step[0];
            OP_MULD:        carry_n = |acc_step;
            default:        carry_n = 1'b0;
          endcase
          if (op_r == OP_CMP) begin
            res_n      = '0;
            res_n[3:0] = acc_step;
          end
        end
      end
      OUT: begin
        if (bus.out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      op_r    <= '0;
      a_r     <= '0;
      b_r     <= '0;
      res_r   <= '0;
      cnt     <= '0;
      acc     <= '0;
      carry_r <= 1'b0;
      error_r <= 1'b0;
    end else begin
      state   <= state_n;
      op_r    <= op_n;
      a_r     <= a_n;
      b_r     <= b_n;
      res_r   <= res_n;
      cnt     <= cnt_n;
      acc     <= acc_n;
      carry_r <= carry_n;
      error_r <= error_n;
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == OUT);
  assign bus.result    = res_r;
  assign bus.carry_out = carry_r;
  assign bus.error     = error_r;
endmodule

// File: tb/tb_base12_seq_alu.sv
// Directed bench for base12_seq_alu (DIGITS=6) with an expected-result queue.
module tb_base12_seq_alu;
  localparam int DIGITS = 6;
  localparam int W = 4 * DIGITS;
  localparam int unsigned MODV = 2985984; // 12**6
  localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, MULD = 3'b010,
                         SHL = 3'b011, SHR = 3'b100, CMP = 3'b101;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  base12_seq_alu_if #(.DIGITS(DIGITS)) bus();
  base12_seq_alu #(.DIGITS(DIGITS)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    logic [W-1:0] res;
    logic         c;
    logic         err;
    int           lat;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned to_val(input logic [W-1:0] v);
    int unsigned r = 0;
    for (int i = DIGITS - 1; i >= 0; i--) r = r * 12 + int'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] from_val(input int unsigned x);
    logic [W-1:0] r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(x % 12);
      x = x / 12;
    end
    return r;
  endfunction

  function automatic logic [W-1:0] rand_operand();
    logic [W-1:0] r = '0;
    for (int i = 0; i < DIGITS; i++) r[4*i +: 4] = 4'($urandom_range(0, 11));
    return r;
  endfunction

  task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    check("in_ready_before_cmd", bus.in_ready, 1);
    bus.in_valid = 1'b1;
    bus.op = op;
    bus.a = a;
    bus.b = b;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.op = 3'($urandom_range(0, 5));
    bus.a = W'($urandom);
    bus.b = W'($urandom);
  endtask

  task automatic run_cmd(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] res, input logic c,
                         input logic err, input int hold);
    exp_t e;
    exp_t got;
    int lat;
    bit seen;
    bit busy_ok;
    logic [W-1:0] held;
    e.res = res; e.c = c; e.err = err; e.lat = err ? 1 : DIGITS + 1;
    sb.push_back(e);
    bus.out_ready = (hold == 0);
    send(op, a, b);
    lat = 1; seen = 0; busy_ok = 1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (bus.out_valid) begin seen = 1; break; end
      if (bus.in_ready) busy_ok = 0;
      @(posedge clk);
      lat++;
    end
    check({tag, "_out_valid_seen"}, seen, 1);
    check({tag, "_in_ready_low_while_busy"}, busy_ok, 1);
    got = sb.pop_front();
    check({tag, "_result"}, bus.result, got.res);
    check({tag, "_carry_out"}, bus.carry_out, got.c);
    check({tag, "_error"}, bus.error, got.err);
    check({tag, "_latency"}, lat, got.lat);
    held = bus.result;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check({tag, "_hold_result"}, bus.result, held);
      check({tag, "_hold_in_ready"}, bus.in_ready, 0);
      check({tag, "_hold_out_valid"}, bus.out_valid, 1);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check({tag, "_in_ready_after_hs"}, bus.in_ready, 1);
    check({tag, "_out_valid_after_hs"}, bus.out_valid, 0);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    int unsigned va, vb;
    bit never_valid;
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    bus.op = '0;
    bus.a = '0;
    bus.b = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_result", bus.result, 0);
    check("rst_carry_out", bus.carry_out, 0);
    check("rst_error", bus.error, 0);

    run_cmd("add_chain", ADD, 24'h0BBBBB, 24'h000001, 24'h100000, 1'b0, 1'b0, 0);
    run_cmd("add_ovf",   ADD, 24'hBBBBBB, 24'h000001, 24'h000000, 1'b1, 1'b0, 0);
    run_cmd("sub_wrap",  SUB, 24'h000000, 24'h000001, 24'hBBBBBB, 1'b1, 1'b0, 0);
    run_cmd("sub_brw",   SUB, 24'h000100, 24'h000001, 24'h0000BB, 1'b0, 1'b0, 0);
    run_cmd("muld_bb",   MULD, 24'h00000B, 24'h00000B, 24'h0000A1, 1'b0, 1'b0, 0);
    run_cmd("muld_ovf",  MULD, 24'hB00000, 24'h000002, 24'hA00000, 1'b1, 1'b0, 0);
    run_cmd("muld_zero", MULD, 24'h12345A, 24'h000010, 24'h000000, 1'b0, 1'b0, 0);
    run_cmd("shl_2",     SHL, 24'h000123, 24'h000002, 24'h012300, 1'b0, 1'b0, 0);
    run_cmd("shr_3",     SHR, 24'h012300, 24'h000003, 24'h000012, 1'b0, 1'b0, 0);
    run_cmd("shl_6",     SHL, 24'h123456, 24'h000006, 24'h000000, 1'b0, 1'b0, 0);
    run_cmd("cmp_gt",    CMP, 24'h100000, 24'h0BBBBB, 24'h000001, 1'b0, 1'b0, 0);
    run_cmd("cmp_lt",    CMP, 24'h0BBBBB, 24'h100000, 24'h000002, 1'b0, 1'b0, 0);
    run_cmd("cmp_eq",    CMP, 24'h0A1B23, 24'h0A1B23, 24'h000000, 1'b0, 1'b0, 0);
    run_cmd("err_digit", ADD, 24'h00000C, 24'h000001, 24'h000000, 1'b0, 1'b1, 0);
    run_cmd("err_op",    3'b110, 24'h000001, 24'h000001, 24'h000000, 1'b0, 1'b1, 0);
    run_cmd("err_clear", ADD, 24'h000005, 24'h000006, 24'h00000B, 1'b0, 1'b0, 0);
    run_cmd("backpress", ADD, 24'h000007, 24'h000008, 24'h000013, 1'b0, 1'b0, 5);

    for (int t = 0; t < 4; t++) begin
      ra = rand_operand();
      rb = rand_operand();
      va = to_val(ra);
      vb = to_val(rb);
      run_cmd("rand_add", ADD, ra, rb, from_val((va + vb) % MODV), (va + vb) >= MODV, 1'b0, 0);
      run_cmd("rand_sub", SUB, ra, rb, from_val((va + MODV - vb) % MODV), va < vb, 1'b0, 0);
    end

    // Reset lands in the third RUN cycle; the aborted command has no queue entry.
    send(ADD, 24'h000005, 24'h000003);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("midrun_rst_in_ready", bus.in_ready, 1);
    check("midrun_rst_out_valid", bus.out_valid, 0);
    check("midrun_rst_result", bus.result, 0);
    check("midrun_rst_carry_out", bus.carry_out, 0);
    check("midrun_rst_error", bus.error, 0);
    never_valid = 1;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (bus.out_valid) never_valid = 0;
    end
    check("midrun_rst_no_output", never_valid, 1);
    run_cmd("post_rst_add", ADD, 24'h0000B5, 24'h000008, 24'h000101, 1'b0, 1'b0, 0);

    check("scoreboard_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
